// File: rtl/gpu_pkg.sv
// gpu_pkg: shared VRAM arbiter state encoding and parameter defaults
package gpu_pkg;

    localparam int DEF_ADDR_W       = 14;
    localparam int DEF_STARVE_LIMIT = 1024;

    typedef enum logic [1:0] {
        IDLE,
        RD_CAP,
        WR_ACK,
        ACK
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM bank between the renderer (absolute priority) and CPU free-cycle access
module vram_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clkPixel,
    input  logic              reset,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic [DATA_W-1:0] gpu_q,
    output logic              gpu_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_d,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_ack,
    output logic              cpu_starved,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t        state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     wait_cnt;
    logic              grant;

    // reset gates the grant so no write strobe escapes during a reset cycle
    assign grant       = state == IDLE && cpu_req && !gpu_req && !reset;
    assign gpu_q       = ram_q;
    assign ram_d       = cpu_d;
    assign cpu_starved = wait_cnt == LIMIT;

    // state register
    always_ff @(posedge clkPixel) begin
        state <= reset ? IDLE : state_nx;
    end

    // next state: reads capture in RD_CAP, both paths finish with a one-cycle ack cooldown
    always_comb begin
        state_nx = state == IDLE   ? (grant ? (cpu_we ? WR_ACK : RD_CAP) : IDLE) :
                   state == RD_CAP ? ACK : IDLE;
    end

    // port mux and handshake outputs; the address holds when nobody uses the bank
    always_comb begin
        ram_we   = grant & cpu_we;
        ram_addr = gpu_req ? gpu_addr : grant ? cpu_addr : addr_q;
        cpu_ack  = state == WR_ACK || state == ACK;
    end

    // datapath registers: held address, renderer valid, CPU read capture, starvation counter
    always_ff @(posedge clkPixel) begin
        if (reset) begin
            addr_q    <= '0;
            gpu_valid <= 1'b0;
            cpu_q     <= '0;
            wait_cnt  <= '0;
        end else begin
            addr_q    <= ram_addr;
            gpu_valid <= gpu_req;
            if (state == RD_CAP)
                cpu_q <= ram_q;
            if (grant)
                wait_cnt <= '0;
            else if (state == IDLE && cpu_req && wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural VRAM bank
module tb_vram_arbiter;

    logic        clkPixel = 1'b0;
    logic        reset    = 1'b1;
    logic        gpu_req  = 1'b0;
    logic [13:0] gpu_addr = '0;
    logic [31:0] gpu_q;
    logic        gpu_valid;
    logic        cpu_req  = 1'b0;
    logic        cpu_we   = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_d    = '0;
    logic [31:0] cpu_q;
    logic        cpu_ack;
    logic        cpu_starved;
    logic [13:0] ram_addr;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q;

    logic [31:0] mem [0:16383];
    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter dut (
        .clkPixel(clkPixel), .reset(reset),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_q(gpu_q), .gpu_valid(gpu_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack), .cpu_starved(cpu_starved),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clkPixel = ~clkPixel;

    // synchronous single-port bank, read-first
    always @(posedge clkPixel) begin
        if (ram_we)
            mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clkPixel);
        #1;
    endtask

    task automatic cpu_set(input logic req, input logic we, input logic [13:0] a, input logic [31:0] d);
        cpu_req  = req;
        cpu_we   = we;
        cpu_addr = a;
        cpu_d    = d;
        #1;
    endtask

    int  starve_at;
    bit  we_seen;
    bit  ack_seen;

    initial begin
        for (int i = 0; i < 16384; i++)
            mem[i] = 32'hA500_0000 | i;
        tick();
        tick();
        check("rst_ack", cpu_ack, 0);
        check("rst_gvalid", gpu_valid, 0);
        check("rst_cpu_q", cpu_q, 0);
        check("rst_we", ram_we, 0);
        check("rst_starved", cpu_starved, 0);
        check("rst_addr", ram_addr, 0);
        reset = 1'b0;
        tick();

        // CPU write into an idle bank
        cpu_set(1, 1, 14'h0123, 32'hDEADBEEF);
        check("wr_we", ram_we, 1);
        check("wr_addr", ram_addr, 14'h0123);
        check("wr_d", ram_d, 32'hDEADBEEF);
        check("wr_ack_early", cpu_ack, 0);
        tick();
        check("wr_ack", cpu_ack, 1);
        check("wr_we_once", ram_we, 0);
        cpu_set(0, 0, 0, 0);
        tick();
        check("wr_ack_single", cpu_ack, 0);
        check("wr_mem", mem[14'h0123], 32'hDEADBEEF);

        // CPU read back
        cpu_set(1, 0, 14'h0123, 0);
        check("rd_we", ram_we, 0);
        check("rd_addr", ram_addr, 14'h0123);
        tick();
        check("rd_ack_n1", cpu_ack, 0);
        tick();
        check("rd_ack_n2", cpu_ack, 1);
        check("rd_q", cpu_q, 32'hDEADBEEF);
        cpu_set(0, 0, 0, 0);
        tick();
        check("rd_ack_single", cpu_ack, 0);
        check("hold_addr", ram_addr, 14'h0123);

        // continuous renderer traffic starves a pending write
        gpu_req  = 1'b1;
        gpu_addr = 14'h0200;
        cpu_set(1, 1, 14'h0055, 32'h12345678);
        starve_at = -1;
        we_seen   = 0;
        ack_seen  = 0;
        for (int i = 0; i < 2000; i++) begin
            if (cpu_starved && starve_at < 0)
                starve_at = i;
            we_seen  |= ram_we;
            ack_seen |= cpu_ack;
            tick();
        end
        check("starve_no_we", we_seen, 0);
        check("starve_no_ack", ack_seen, 0);
        check("starve_cycle", starve_at, 1024);
        check("starve_held", cpu_starved, 1);
        check("starve_gaddr", ram_addr, 14'h0200);
        gpu_req = 1'b0;
        #1;
        check("starve_grant_we", ram_we, 1);
        check("starve_grant_addr", ram_addr, 14'h0055);
        tick();
        check("starve_clear", cpu_starved, 0);
        check("starve_ack", cpu_ack, 1);
        cpu_set(0, 0, 0, 0);
        tick();
        check("starve_mem", mem[14'h0055], 32'h12345678);

        // renderer and CPU request together: renderer wins
        gpu_req  = 1'b1;
        gpu_addr = 14'h0010;
        cpu_set(1, 0, 14'h0020, 0);
        check("tie_addr", ram_addr, 14'h0010);
        check("tie_we", ram_we, 0);
        tick();
        check("tie_gvalid", gpu_valid, 1);
        check("tie_gq", gpu_q, 32'hA5000010);
        check("tie_no_ack", cpu_ack, 0);
        gpu_req = 1'b0;
        #1;
        check("tie_grant_addr", ram_addr, 14'h0020);
        tick();
        check("tie_gvalid_off", gpu_valid, 0);
        tick();
        check("tie_ack", cpu_ack, 1);
        check("tie_q", cpu_q, 32'hA5000020);
        cpu_set(0, 0, 0, 0);
        tick();

        // renderer fetch pipelined directly behind a CPU read
        cpu_set(1, 0, 14'h0123, 0);
        tick();
        gpu_req  = 1'b1;
        gpu_addr = 14'h0030;
        #1;
        check("pipe_gaddr", ram_addr, 14'h0030);
        tick();
        gpu_req = 1'b0;
        #1;
        check("pipe_ack", cpu_ack, 1);
        check("pipe_cpu_q", cpu_q, 32'hDEADBEEF);
        check("pipe_gvalid", gpu_valid, 1);
        check("pipe_gq", gpu_q, 32'hA5000030);
        cpu_set(0, 0, 0, 0);
        tick();

        // reset while capturing a read discards the ack
        cpu_set(1, 0, 14'h0020, 0);
        tick();
        reset = 1'b1;
        #1;
        check("rstmid_no_ack", cpu_ack, 0);
        tick();
        reset = 1'b0;
        cpu_set(0, 0, 0, 0);
        check("rstmid_ack", cpu_ack, 0);
        check("rstmid_cpu_q", cpu_q, 0);
        check("rstmid_addr", ram_addr, 0);
        check("rstmid_we", ram_we, 0);
        check("rstmid_starved", cpu_starved, 0);
        tick();
        check("rstmid_ack_late", cpu_ack, 0);

        // fresh write and read after reset
        cpu_set(1, 1, 14'h0077, 32'hCAFEF00D);
        check("post_we", ram_we, 1);
        tick();
        check("post_wr_ack", cpu_ack, 1);
        cpu_set(0, 0, 0, 0);
        tick();
        cpu_set(1, 0, 14'h0077, 0);
        tick();
        tick();
        check("post_rd_ack", cpu_ack, 1);
        check("post_rd_q", cpu_q, 32'hCAFEF00D);
        cpu_set(0, 0, 0, 0);
        tick();
        check("post_idle", cpu_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
